// File: rtl/dmau_pkg.sv
// Shared types and lane constants for the data-memory access unit.
// The misaligned-access check is only consumed when DMAU_MISALIGN_TRAP_EN is defined.
package dmau_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_WORD   = 2'b10,
    SZ_WORD_X = 2'b11
  } dmau_size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDATA,
    ST_RESP
  } dmau_state_e;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam logic [WORD_W-1:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [WORD_W-1:0] HALF_LANE_MASK = 32'h0000_FFFF;

  function automatic logic is_misaligned(input dmau_size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dmau_lane_align.sv
// Combinational lane steering: store data replication / byte-write masks,
// and load lane extraction with sign or zero extension.
module dmau_lane_align
  import dmau_pkg::*;
(
  input  dmau_size_e        st_size,
  input  logic [1:0]        st_addr_lo,
  input  logic [WORD_W-1:0] st_wdata,
  output logic [WORD_W-1:0] dm_in,
  output logic [WORD_W-1:0] dm_bweb,
  input  dmau_size_e        ld_size,
  input  logic [1:0]        ld_addr_lo,
  input  logic              ld_unsigned,
  input  logic [WORD_W-1:0] ld_rdata,
  output logic [WORD_W-1:0] ld_data
);

  logic signed [BYTE_W-1:0] byte_s;
  logic signed [HALF_W-1:0] half_s;
  logic signed [WORD_W-1:0] byte_ext;
  logic signed [WORD_W-1:0] half_ext;

  always_comb begin
    dm_in   = st_wdata;
    dm_bweb = '0;
    case (st_size)
      SZ_BYTE: begin
        dm_in   = {4{st_wdata[BYTE_W-1:0]}};
        dm_bweb = ~(BYTE_LANE_MASK << {st_addr_lo, 3'b000});
      end
      SZ_HALF: begin
        dm_in   = {2{st_wdata[HALF_W-1:0]}};
        dm_bweb = ~(HALF_LANE_MASK << {st_addr_lo[1], 4'b0000});
      end
      default: ;
    endcase
  end

  // Half accesses only look at addr[1]; word accesses ignore the low bits entirely.
  always_comb begin
    byte_s   = signed'(ld_rdata[{ld_addr_lo, 3'b000} +: BYTE_W]);
    half_s   = signed'(ld_rdata[{ld_addr_lo[1], 4'b0000} +: HALF_W]);
    byte_ext = byte_s;
    half_ext = half_s;
    ld_data  = ld_rdata;
    case (ld_size)
      SZ_BYTE: ld_data = ld_unsigned ? {24'd0, byte_s} : byte_ext;
      SZ_HALF: ld_data = ld_unsigned ? {16'd0, half_s} : half_ext;
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// CPU load/store front end for a single-port SRAM with active-low controls.
// Define DMAU_MISALIGN_TRAP_EN to report misaligned half/word accesses via rsp_err.
module dm_access_unit
  import dmau_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              DM_CEB,
  output logic              DM_WEB,
  output logic [31:0]       DM_BWEB,
  output logic [ADDR_W-3:0] DM_A,
  output logic [31:0]       DM_IN,
  input  logic [31:0]       DM_OUT
);

  dmau_state_e state_q, state_d;

  logic        accept;
  logic        misalign;
  logic        we_p0;
  logic        unsigned_p0;
  dmau_size_e  size_p0;
  logic [1:0]  addr_lo_p0;
  logic [31:0] bweb_p0;
  logic        err_p0;
  logic [31:0] st_din;
  logic [31:0] st_bweb;
  logic [31:0] ld_data;
  logic        store_access;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef DMAU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(dmau_size_e'(req_size), req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif

  dmau_lane_align u_lane_align (
    .st_size     (dmau_size_e'(req_size)),
    .st_addr_lo  (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .dm_in       (st_din),
    .dm_bweb     (st_bweb),
    .ld_size     (size_p0),
    .ld_addr_lo  (addr_lo_p0),
    .ld_unsigned (unsigned_p0),
    .ld_rdata    (DM_OUT),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = misalign ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = we_p0 ? ST_RESP : ST_RDATA;
      ST_RDATA:  state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Accept stage: request fields and SRAM address/data are latched at the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p0       <= 1'b0;
      unsigned_p0 <= 1'b0;
      size_p0     <= SZ_BYTE;
      addr_lo_p0  <= 2'b00;
      bweb_p0     <= '1;
      err_p0      <= 1'b0;
      rsp_rdata   <= '0;
      DM_A        <= '0;
      DM_IN       <= '0;
    end else begin
      if (accept) begin
        we_p0       <= req_we;
        unsigned_p0 <= req_unsigned;
        size_p0     <= dmau_size_e'(req_size);
        addr_lo_p0  <= req_addr[1:0];
        err_p0      <= misalign;
        rsp_rdata   <= '0;
        if (!misalign) begin
          DM_A <= req_addr[ADDR_W-1:2];
          if (req_we) begin
            DM_IN   <= st_din;
            bweb_p0 <= st_bweb;
          end
        end
      end
      // Read stage: SRAM output is valid one cycle after the access cycle.
      if (state_q == ST_RDATA) rsp_rdata <= ld_data;
    end
  end

  assign store_access = (state_q == ST_ACCESS) && we_p0;
  assign DM_CEB       = (state_q != ST_ACCESS);
  assign DM_WEB       = !store_access;
  assign DM_BWEB      = store_access ? bweb_p0 : '1;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_err      = err_p0;

endmodule
